// File: rtl/yuv420_frame_ctrl_pkg.sv
// Stream data-type codes and widths shared by the yuv420 frame controller and its neighbours.
package yuv420_frame_ctrl_pkg;

  localparam int unsigned DTYPE_WIDTH = 8;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_IDLE        = 8'h00;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 8'h01;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'h0f;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h10;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h20;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 8'h40;

  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
    return (dt & DTYPE_PIXEL_MASK) != '0;
  endfunction

endpackage

// File: rtl/yuv420_frame_ctrl.sv
// Frame-synchronous config apply and frame decimation in front of the yuv420 packer.
// Config changes take effect only at a frame start; dropped frames emit no beats.
module yuv420_frame_ctrl
  import yuv420_frame_ctrl_pkg::*;
#(
  parameter logic [15:0] DEFAULT_IMAGE_TYPE = 16'd1,
  parameter logic        DEFAULT_ENABLE     = 1'b1,
  parameter logic [3:0]  DEFAULT_DECIMATE   = 4'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_stb,
  input  logic [15:0]            cfg_image_type,
  input  logic                   cfg_enable,
  input  logic [3:0]             cfg_decimate,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [7:0]             yi,
  input  logic [7:0]             ui,
  input  logic [7:0]             vi,
  input  logic [15:0]            meta_datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [7:0]             yo,
  output logic [7:0]             uo,
  output logic [7:0]             vo,
  output logic [15:0]            meta_datao,
  output logic [15:0]            image_type,
  output logic                   enable,
  output logic                   cfg_pending,
  output logic                   in_frame,
  output logic [15:0]            frame_count,
  output logic [15:0]            drop_count,
  output logic [7:0]             err_count,
  output logic [23:0]            last_pixels
);

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] pend_type_q, pend_type_d;
  logic        pend_en_q, pend_en_d;
  logic [3:0]  pend_dec_q, pend_dec_d;
  logic        pending_q, pending_d;
  logic [15:0] type_q, type_d;
  logic        en_q, en_d;
  logic [3:0]  dec_q, dec_d;
  logic [3:0]  skip_q, skip_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] drop_q, drop_d;
  logic [7:0]  err_q, err_d;
  logic [23:0] pix_q, pix_d;
  logic [23:0] last_q, last_d;
  logic        dvo_q, dvo_d;

  logic       frame_start, frame_end, pixel, gate, err_inc;
  logic [3:0] eff_dec, eff_skip;

  assign frame_start = dvi && (dtypei == DTYPE_FRAME_START);
  assign frame_end   = dvi && (dtypei == DTYPE_FRAME_END);
  assign pixel       = dvi && is_pixel(dtypei);

  always_comb begin
    state_d     = state_q;
    pend_type_d = pend_type_q;
    pend_en_d   = pend_en_q;
    pend_dec_d  = pend_dec_q;
    pending_d   = pending_q;
    type_d      = type_q;
    en_d        = en_q;
    dec_d       = dec_q;
    skip_d      = skip_q;
    frame_d     = frame_q;
    drop_d      = drop_q;
    err_d       = err_q;
    pix_d       = pix_q;
    last_d      = last_q;
    gate        = (state_q != StDrop);
    err_inc     = 1'b0;
    eff_dec     = dec_q;
    eff_skip    = skip_q;

    if (frame_start) begin
      err_inc = (state_q != StIdle);
      if (pending_q) begin
        type_d    = pend_type_q;
        en_d      = pend_en_q;
        dec_d     = pend_dec_q;
        eff_dec   = pend_dec_q;
        eff_skip  = '0;
        pending_d = 1'b0;
      end
      if (eff_skip == '0) begin
        state_d = StPass;
        skip_d  = eff_dec;
      end else begin
        state_d = StDrop;
        skip_d  = eff_skip - 4'd1;
      end
      // Start beat follows the state it opens.
      gate  = (eff_skip == '0);
      pix_d = '0;
    end else if (frame_end) begin
      unique case (state_q)
        StPass: begin
          frame_d = frame_q + 16'd1;
          last_d  = pix_q + 24'(pixel);
        end
        StDrop: begin
          drop_d = drop_q + 16'd1;
          gate   = 1'b0;
        end
        default: begin
          err_inc = 1'b1;
          gate    = 1'b0;
        end
      endcase
      state_d = StIdle;
    end else if (pixel && (state_q == StPass)) begin
      pix_d = pix_q + 24'd1;
    end

    if (err_inc && (err_q != 8'hff)) begin
      err_d = err_q + 8'd1;
    end

    // A strobe coinciding with an apply refills pending after the old values are consumed.
    if (cfg_stb) begin
      pend_type_d = cfg_image_type;
      pend_en_d   = cfg_enable;
      pend_dec_d  = cfg_decimate;
      pending_d   = 1'b1;
    end

    dvo_d = dvi & gate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_type_q <= DEFAULT_IMAGE_TYPE;
      pend_en_q   <= DEFAULT_ENABLE;
      pend_dec_q  <= DEFAULT_DECIMATE;
      pending_q   <= 1'b0;
      type_q      <= DEFAULT_IMAGE_TYPE;
      en_q        <= DEFAULT_ENABLE;
      dec_q       <= DEFAULT_DECIMATE;
      skip_q      <= '0;
      frame_q     <= '0;
      drop_q      <= '0;
      err_q       <= '0;
      pix_q       <= '0;
      last_q      <= '0;
      dvo_q       <= 1'b0;
      dtypeo      <= '0;
      yo          <= '0;
      uo          <= '0;
      vo          <= '0;
      meta_datao  <= '0;
    end else begin
      state_q     <= state_d;
      pend_type_q <= pend_type_d;
      pend_en_q   <= pend_en_d;
      pend_dec_q  <= pend_dec_d;
      pending_q   <= pending_d;
      type_q      <= type_d;
      en_q        <= en_d;
      dec_q       <= dec_d;
      skip_q      <= skip_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      pix_q       <= pix_d;
      last_q      <= last_d;
      dvo_q       <= dvo_d;
      dtypeo      <= dtypei;
      yo          <= yi;
      uo          <= ui;
      vo          <= vi;
      meta_datao  <= meta_datai;
    end
  end

  assign dvo         = dvo_q;
  assign image_type  = type_q;
  assign enable      = en_q;
  assign cfg_pending = pending_q;
  assign in_frame    = (state_q != StIdle);
  assign frame_count = frame_q;
  assign drop_count  = drop_q;
  assign err_count   = err_q;
  assign last_pixels = last_q;

endmodule

// File: doc/yuv420_frame_ctrl.md
YUV420_FRAME_CTRL -- requirements
Module: yuv420_frame_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_IMAGE_TYPE, 16'd1, image_type value driven after reset.
REQ-002 SHALL have parameter DEFAULT_ENABLE, 1'b1, enable value driven after reset.
REQ-003 SHALL have parameter DEFAULT_DECIMATE, 4'd0, decimation value active after reset.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_stb  input  1  one-cycle strobe that captures the cfg_* inputs.
REQ-007 SHALL have ports cfg_image_type/cfg_enable/cfg_decimate  input  16/1/4  requested configuration.
REQ-008 SHALL have ports dvi, dtypei, yi, ui, vi, meta_datai  input  1/`DTYPE_WIDTH/8/8/8/16  upstream stream.
REQ-009 SHALL have ports dvo, dtypeo, yo, uo, vo, meta_datao  output  same widths  gated stream to the yuv420 packer.
REQ-010 SHALL have ports image_type, enable  output  16/1  active configuration for the packer.
REQ-011 SHALL have ports cfg_pending, in_frame  output  1/1  status flags.
REQ-012 SHALL have ports frame_count, drop_count, err_count, last_pixels  output  16/16/8/24  statistics.

Function
REQ-013 SHALL have three states: IDLE (between frames), PASS and DROP.
REQ-014 SHALL register all stream outputs with 1-cycle latency; data fields pass unmodified; dvo = registered (dvi AND gate).
REQ-015 SHALL define "frame start" as dvi AND dtypei==`DTYPE_FRAME_START, and "frame end" likewise with `DTYPE_FRAME_END.
REQ-016 SHALL, on cfg_stb, load the pending registers from cfg_* and set cfg_pending=1; a later strobe before apply overwrites the pending values.
REQ-017 SHALL, on a frame start with cfg_pending=1, copy pending to image_type/enable/decimate on that edge, clear cfg_pending and zero skip_cnt.
REQ-018 SHALL, when cfg_stb and an applying frame start coincide, apply the old pending values, capture the new ones into pending, and keep cfg_pending=1.
REQ-019 SHALL, on a frame start, evaluate skip_cnt after any apply: 0 -> PASS with skip_cnt<=decimate; nonzero -> DROP with skip_cnt<=skip_cnt-1. One of every decimate+1 frames passes.
REQ-020 SHALL gate with gate=1 in PASS and gate=0 in DROP; the frame-start beat takes the new state and the frame-end beat takes the old state, so a dropped frame emits no beats from start through end inclusive.
REQ-021 SHALL pass beats in IDLE with dvi=1 (headers, idle markers), except a stray frame end.
REQ-022 SHALL handle a frame start while in PASS or DROP: increment err_count, then treat the beat as a normal frame start.
REQ-023 SHALL handle a frame end in IDLE: increment err_count and suppress the beat (dvo=0).
REQ-024 SHALL saturate err_count at 255; frame_count and drop_count wrap at 16 bits.
REQ-025 SHALL update statistics on frame end: frame_count+1 from PASS, drop_count+1 from DROP.
REQ-026 SHALL count pixel beats (dvi AND (dtypei & `DTYPE_PIXEL_MASK)!=0) in PASS into a 24-bit counter cleared at frame start; on frame end from PASS, last_pixels SHALL latch the final count, including the current beat.
REQ-027 SHALL drive in_frame=1 in PASS or DROP.
REQ-028 SHALL change state only on beats with dvi=1.

Reset
REQ-029 SHALL, while reset is asserted, drive: state IDLE; dvo=0; dtypeo, yo, uo, vo, meta_datao = 0; image_type=DEFAULT_IMAGE_TYPE; enable=DEFAULT_ENABLE; decimate=DEFAULT_DECIMATE; cfg_pending=0; skip_cnt, counters and last_pixels = 0.
REQ-030 SHALL, on reset mid-frame, abandon the frame; the first post-reset frame start is evaluated as PASS.

Structure
REQ-031 SHALL take the DTYPE_* constants and widths from the shared dtypes.v header; no new constants.
REQ-032 SHALL be a single flat module with no sub-module; the state encoding is local.

Verification
REQ-033 SHALL cover: decimate=2 over 6 frames -> frames 1 and 4 pass, frame_count=2, drop_count=4, no beats from dropped frames.
REQ-034 SHALL cover: cfg_stb mid-frame with image_type 0 -> image_type unchanged until the next frame-start edge; cfg_pending 1->0 at that edge.
REQ-035 SHALL cover: cfg_stb coincident with an applying frame start -> old pending applied, new values applied at the following frame start.
REQ-036 SHALL cover: a 4x3 pixel frame in PASS -> last_pixels=12; each dvo beat equals the input beat delayed 1 cycle.
REQ-037 SHALL cover: frame start without frame end, then a stray frame end in IDLE -> err_count=2, stray beat suppressed.
REQ-038 SHALL cover: reset asserted mid-PASS -> all outputs at reset values immediately; next frame passes with the default configuration.
